vga_rect_scheduler: RTL and testbench

- Animates three coloured rectangles over the 640x480 scan produced by the vga timing block.
- Once per frame, on the falling edge of VS, a small FSM updates each rectangle's position in turn through one shared adder/compare unit. Rectangles bounce off the screen edges.
- Per pixel, the block resolves rectangle coverage into RED/GREEN/BLUE, either by additive mixing or by fixed priority.
- Sits between the vga timing block (x, y, VS) and the colour output pins.

---
 rtl/vga_rect_scheduler.sv | 276 +++++++++++++++++++++++++++
 tb/tb_vga_rect_scheduler.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_rect_scheduler.sv
`default_nettype none
//==============================================================================
//  Module   : vga_rect_scheduler
//  Purpose  : Animates three coloured rectangles over a 640x480 scan. The
//             rectangle positions are stepped once per frame, and each rectangle
//             bounces off the screen edges. The update runs in vertical blanking
//             on a single shared per-axis step/bounce unit. Each pixel is then
//             coloured by additive mixing or by fixed priority.
//  Revision : 1.0  - initial release
//------------------------------------------------------------------------------
//  Ports
//    CLK       in   1   pixel clock, shared with the vga timing block
//    RESET_N   in   1   asynchronous active-low reset
//    x         in  10   current pixel column
//    y         in  10   current pixel row
//    VS        in   1   vertical sync, active low; its falling edge is the tick
//    PAUSE     in   1   1 = hold positions at frame ticks
//    STEP_REQ  in   1   one-cycle pulse: allow one update while paused
//    MODE      in   1   0 = additive mixing, 1 = priority rect0 > rect1 > rect2
//    RED       out  4   red level   (registered, 1 cycle after x/y)
//    GREEN     out  4   green level (registered, 1 cycle after x/y)
//    BLUE      out  4   blue level  (registered, 1 cycle after x/y)
//    BUSY      out  1   high while the position-update FSM is not idle
//==============================================================================
module vga_rect_scheduler #(
   parameter int H_ACTIVE = 640,
   parameter int V_ACTIVE = 480,
   parameter int STEP     = 2,
   parameter int W0       = 300,
   parameter int H0       = 300,
   parameter int W1       = 200,
   parameter int H1       = 200,
   parameter int W2       = 300,
   parameter int H2       = 300
) (
   input  logic       CLK,
   input  logic       RESET_N,
   input  logic [9:0] x,
   input  logic [9:0] y,
   input  logic       VS,
   input  logic       PAUSE,
   input  logic       STEP_REQ,
   input  logic       MODE,
   output logic [3:0] RED,
   output logic [3:0] GREEN,
   output logic [3:0] BLUE,
   output logic       BUSY
);

   // All geometry is carried at 11 bits so that pos + size never wraps.
   localparam logic [10:0] c_h_act = 11'(H_ACTIVE);
   localparam logic [10:0] c_v_act = 11'(V_ACTIVE);
   localparam logic [10:0] c_step  = 11'(STEP);

   localparam logic [2:0][10:0] c_w = {11'(W2), 11'(W1), 11'(W0)};
   localparam logic [2:0][10:0] c_h = {11'(H2), 11'(H1), 11'(H0)};

   // Start-up placement. A direction bit of 1 means the rectangle is moving
   // towards 0 on that axis.
   localparam logic [2:0][10:0] c_px_rst = {11'd300, 11'd200, 11'd0};
   localparam logic [2:0][10:0] c_py_rst = {11'd180, 11'd150, 11'd0};
   localparam logic [2:0]       c_dx_rst = 3'b010;
   localparam logic [2:0]       c_dy_rst = 3'b100;

   localparam logic [1:0] c_st_idle = 2'd0;
   localparam logic [1:0] c_st_upd0 = 2'd1;
   localparam logic [1:0] c_st_upd1 = 2'd2;
   localparam logic [1:0] c_st_upd2 = 2'd3;

   logic [1:0]       r_state;
   logic [1:0]       w_state_nxt;
   logic             r_vs_d;
   logic             w_tick;
   logic             r_step_pend;
   logic             w_consume;

   logic [2:0][10:0] r_px;
   logic [2:0][10:0] r_py;
   logic [2:0]       r_dx;
   logic [2:0]       r_dy;

   logic             w_busy;
   logic             w_upd_en;
   logic [1:0]       w_sel;

   logic [10:0]      w_cur_x;
   logic [10:0]      w_cur_y;
   logic [10:0]      w_sz_x;
   logic [10:0]      w_sz_y;
   logic             w_cur_dx;
   logic             w_cur_dy;
   logic [11:0]      w_res_x;
   logic [11:0]      w_res_y;

   logic             w_vis;
   logic [2:0]       w_in;
   logic [3:0]       w_red;
   logic [3:0]       w_green;
   logic [3:0]       w_blue;
   logic [3:0]       r_red;
   logic [3:0]       r_green;
   logic [3:0]       r_blue;

   //---------------------------------------------------------------------------
   // One axis of the step/bounce unit. Returns {new_dir, new_pos}.
   // Moving up: clamp to lim - size and reverse if the far edge would overrun.
   // Moving down: clamp to 0 and reverse if a full step is not available.
   //---------------------------------------------------------------------------
   function automatic logic [11:0] axis_step(input logic [10:0] pos,
                                             input logic [10:0] size,
                                             input logic [10:0] lim,
                                             input logic        neg);
      logic [10:0] nxt;
      nxt = pos + c_step;
      if (!neg) begin
         if ((nxt + size) > lim) return {1'b1, lim - size};
         else                    return {1'b0, nxt};
      end else begin
         if (pos < c_step)       return {1'b0, 11'd0};
         else                    return {1'b1, pos - c_step};
      end
   endfunction

   //---------------------------------------------------------------------------
   // Frame tick and single-step request
   //---------------------------------------------------------------------------
   assign w_tick    = r_vs_d & ~VS;
   assign w_consume = (r_state == c_st_idle) & w_tick & (~PAUSE | r_step_pend);

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_vs_d      <= 1'b1;
         r_step_pend <= 1'b0;
      end else begin
         r_vs_d      <= VS;
         // A new request arriving in the consuming cycle must survive.
         r_step_pend <= STEP_REQ | (r_step_pend & ~w_consume);
      end
   end

   //---------------------------------------------------------------------------
   // Update FSM: state register
   //---------------------------------------------------------------------------
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) r_state <= c_st_idle;
      else          r_state <= w_state_nxt;
   end

   //---------------------------------------------------------------------------
   // Update FSM: next state. Ticks outside IDLE are simply not looked at.
   //---------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_st_idle: if (w_consume) w_state_nxt = c_st_upd0;
         c_st_upd0: w_state_nxt = c_st_upd1;
         c_st_upd1: w_state_nxt = c_st_upd2;
         c_st_upd2: w_state_nxt = c_st_idle;
         default:   w_state_nxt = c_st_idle;
      endcase
   end

   //---------------------------------------------------------------------------
   // Update FSM: outputs (rectangle select for the shared unit)
   //---------------------------------------------------------------------------
   always_comb begin
      w_busy   = 1'b0;
      w_upd_en = 1'b0;
      w_sel    = 2'd0;
      case (r_state)
         c_st_upd0: begin w_busy = 1'b1; w_upd_en = 1'b1; w_sel = 2'd0; end
         c_st_upd1: begin w_busy = 1'b1; w_upd_en = 1'b1; w_sel = 2'd1; end
         c_st_upd2: begin w_busy = 1'b1; w_upd_en = 1'b1; w_sel = 2'd2; end
         default:   ;
      endcase
   end

   //---------------------------------------------------------------------------
   // Operand select into the shared step/bounce unit
   //---------------------------------------------------------------------------
   always_comb begin
      w_cur_x  = r_px[0];
      w_cur_y  = r_py[0];
      w_cur_dx = r_dx[0];
      w_cur_dy = r_dy[0];
      w_sz_x   = c_w[0];
      w_sz_y   = c_h[0];
      case (w_sel)
         2'd1: begin
            w_cur_x  = r_px[1];
            w_cur_y  = r_py[1];
            w_cur_dx = r_dx[1];
            w_cur_dy = r_dy[1];
            w_sz_x   = c_w[1];
            w_sz_y   = c_h[1];
         end
         2'd2: begin
            w_cur_x  = r_px[2];
            w_cur_y  = r_py[2];
            w_cur_dx = r_dx[2];
            w_cur_dy = r_dy[2];
            w_sz_x   = c_w[2];
            w_sz_y   = c_h[2];
         end
         default: ;
      endcase
   end

   assign w_res_x = axis_step(w_cur_x, w_sz_x, c_h_act, w_cur_dx);
   assign w_res_y = axis_step(w_cur_y, w_sz_y, c_v_act, w_cur_dy);

   //---------------------------------------------------------------------------
   // Position / direction registers; written only in the UPDn states
   //---------------------------------------------------------------------------
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_px <= c_px_rst;
         r_py <= c_py_rst;
         r_dx <= c_dx_rst;
         r_dy <= c_dy_rst;
      end else if (w_upd_en) begin
         r_px[w_sel] <= w_res_x[10:0];
         r_dx[w_sel] <= w_res_x[11];
         r_py[w_sel] <= w_res_y[10:0];
         r_dy[w_sel] <= w_res_y[11];
      end
   end

   //---------------------------------------------------------------------------
   // Per-pixel coverage
   //---------------------------------------------------------------------------
   assign w_vis = ({1'b0, x} < c_h_act) & ({1'b0, y} < c_v_act);

   for (genvar n = 0; n < 3; n++) begin : g_rect
      assign w_in[n] = ({1'b0, x} >= r_px[n]) & ({1'b0, x} < (r_px[n] + c_w[n])) &
                       ({1'b0, y} >= r_py[n]) & ({1'b0, y} < (r_py[n] + c_h[n])) &
                       w_vis;
   end

   //---------------------------------------------------------------------------
   // Colour resolution
   //---------------------------------------------------------------------------
   always_comb begin
      w_red   = 4'h0;
      w_green = 4'h0;
      w_blue  = 4'h0;
      if (MODE) begin
         if (w_in[0])      w_red   = 4'hF;
         else if (w_in[1]) w_green = 4'hF;
         else if (w_in[2]) w_blue  = 4'hF;
      end else begin
         if (w_in[0]) w_red   = 4'hF;
         if (w_in[1]) w_green = 4'hF;
         if (w_in[2]) w_blue  = 4'hF;
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_red   <= 4'h0;
         r_green <= 4'h0;
         r_blue  <= 4'h0;
      end else begin
         r_red   <= w_red;
         r_green <= w_green;
         r_blue  <= w_blue;
      end
   end

   assign RED   = r_red;
   assign GREEN = r_green;
   assign BLUE  = r_blue;
   assign BUSY  = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_vga_rect_scheduler.sv
`default_nettype none
//==============================================================================
//  Module   : tb_vga_rect_scheduler
//  Purpose  : Self-checking bench for vga_rect_scheduler. Stimulus pushes the
//             expected values into scoreboards. A monitor compares positions
//             when each update completes, and colours one cycle after a pixel
//             is presented.
//  Revision : 1.0  - initial release
//==============================================================================
module tb_vga_rect_scheduler;

   logic       CLK = 1'b0;
   logic       RESET_N;
   logic [9:0] x;
   logic [9:0] y;
   logic       VS;
   logic       PAUSE;
   logic       STEP_REQ;
   logic       MODE;
   logic [3:0] RED;
   logic [3:0] GREEN;
   logic [3:0] BLUE;
   logic       BUSY;

   vga_rect_scheduler dut (
      .CLK      (CLK),
      .RESET_N  (RESET_N),
      .x        (x),
      .y        (y),
      .VS       (VS),
      .PAUSE    (PAUSE),
      .STEP_REQ (STEP_REQ),
      .MODE     (MODE),
      .RED      (RED),
      .GREEN    (GREEN),
      .BLUE     (BLUE),
      .BUSY     (BUSY)
   );

   initial forever #5 CLK = ~CLK;

   typedef struct { int upd_no; int rect; int axis; int pos; int dir; } pos_exp_t;
   typedef struct { int r; int g; int b; } col_exp_t;

   pos_exp_t pos_q[$];
   col_exp_t col_q[$];
   pos_exp_t pe;
   col_exp_t ce;

   int n_chk       = 0;
   int n_fail      = 0;
   int upd_cnt     = 0;
   int busy_run    = 0;
   int busy_cycles = 0;
   logic pix_vld   = 1'b0;
   logic pix_vld_d = 1'b0;

   int rst_px [3] = '{0, 200, 300};
   int rst_py [3] = '{0, 150, 180};
   int rst_dx [3] = '{0, 1, 0};
   int rst_dy [3] = '{0, 0, 1};

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int act_pos(input int r, input int axis);
      if (axis != 0) return int'(dut.r_py[r]);
      else           return int'(dut.r_px[r]);
   endfunction

   function automatic int act_dir(input int r, input int axis);
      if (axis != 0) return int'(dut.r_dy[r]);
      else           return int'(dut.r_dx[r]);
   endfunction

   task automatic expect_pos(input int u, input int r, input int ax, input int p, input int d);
      pos_exp_t e;
      e.upd_no = u; e.rect = r; e.axis = ax; e.pos = p; e.dir = d;
      pos_q.push_back(e);
   endtask

   task automatic push_first_update();
      expect_pos(1, 0, 0,   2, 0);
      expect_pos(1, 0, 1,   2, 0);
      expect_pos(1, 1, 0, 198, 1);
      expect_pos(1, 1, 1, 152, 0);
      expect_pos(1, 2, 0, 302, 0);
      expect_pos(1, 2, 1, 178, 1);
   endtask

   task automatic check_rst_state(input string tag);
      for (int r = 0; r < 3; r++) begin
         check($sformatf("%s_r%0d_x", tag, r),  act_pos(r, 0), rst_px[r]);
         check($sformatf("%s_r%0d_y", tag, r),  act_pos(r, 1), rst_py[r]);
         check($sformatf("%s_r%0d_dx", tag, r), act_dir(r, 0), rst_dx[r]);
         check($sformatf("%s_r%0d_dy", tag, r), act_dir(r, 1), rst_dy[r]);
      end
   endtask

   // Present one pixel for one cycle and queue the colour it must produce.
   task automatic pix(input int px, input int py, input logic md,
                      input int r, input int g, input int b);
      col_exp_t e;
      @(posedge CLK); #1;
      x = 10'(px); y = 10'(py); MODE = md; pix_vld = 1'b1;
      e.r = r; e.g = g; e.b = b;
      col_q.push_back(e);
      @(posedge CLK); #1;
      pix_vld = 1'b0;
   endtask

   // One frame: VS falls (tick), stays low long enough for the update.
   task automatic frame();
      @(posedge CLK); #1 VS = 1'b0;
      repeat (6) @(posedge CLK);
      #1 VS = 1'b1;
      repeat (4) @(posedge CLK);
   endtask

   //---------------------------------------------------------------------------
   // Monitor: busy-run length, position scoreboard, colour scoreboard
   //---------------------------------------------------------------------------
   always @(posedge CLK) pix_vld_d <= pix_vld;

   always @(negedge CLK) begin
      if (!RESET_N) begin
         busy_run = 0;
         upd_cnt  = 0;
      end else if (BUSY) begin
         busy_run++;
         busy_cycles++;
      end else if (busy_run != 0) begin
         check("busy_len", busy_run, 3);
         busy_run = 0;
         upd_cnt++;
         while (pos_q.size() != 0 && pos_q[0].upd_no == upd_cnt) begin
            pe = pos_q.pop_front();
            check($sformatf("upd%0d_r%0d_%s_pos", pe.upd_no, pe.rect, pe.axis ? "y" : "x"),
                  act_pos(pe.rect, pe.axis), pe.pos);
            check($sformatf("upd%0d_r%0d_%s_dir", pe.upd_no, pe.rect, pe.axis ? "y" : "x"),
                  act_dir(pe.rect, pe.axis), pe.dir);
         end
      end
      if (pix_vld_d && RESET_N) begin
         if (col_q.size() == 0) begin
            check("col_q_underflow", 1, 0);
         end else begin
            ce = col_q.pop_front();
            check("pix_red",   int'(RED),   ce.r);
            check("pix_green", int'(GREEN), ce.g);
            check("pix_blue",  int'(BLUE),  ce.b);
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout, expected end of stimulus");
      $fatal(1, "watchdog");
   end

   //---------------------------------------------------------------------------
   // Stimulus
   //---------------------------------------------------------------------------
   initial begin
      int bc0;
      logic found;
      VS = 1'b1; x = '0; y = '0; PAUSE = 1'b0; STEP_REQ = 1'b0; MODE = 1'b0;
      RESET_N = 1'b0;
      repeat (3) @(posedge CLK);
      #1 RESET_N = 1'b1;

      // Reset state
      @(negedge CLK);
      check("rst_busy",  int'(BUSY),  0);
      check("rst_red",   int'(RED),   0);
      check("rst_green", int'(GREEN), 0);
      check("rst_blue",  int'(BLUE),  0);
      check("rst_state", int'(dut.r_state), 0);
      check_rst_state("rst");

      // Colour at reset positions
      pix(250, 200, 1'b0, 15, 15,  0);
      pix(250, 200, 1'b1, 15,  0,  0);
      pix(650,  10, 1'b0,  0,  0,  0);
      pix(450, 300, 1'b0,  0,  0, 15);
      pix(399, 349, 1'b0,  0, 15, 15);
      pix(399, 349, 1'b1,  0, 15,  0);
      pix(400, 350, 1'b0,  0,  0, 15);
      pix(599, 479, 1'b0,  0,  0, 15);
      pix(639, 479, 1'b0,  0,  0,  0);
      pix(100, 600, 1'b0,  0,  0,  0);
      MODE = 1'b0;
      repeat (3) @(posedge CLK);

      // Expected positions along the free-running sequence
      push_first_update();
      expect_pos( 20, 2, 0, 340, 0);
      expect_pos( 21, 2, 0, 340, 1);
      expect_pos( 65, 1, 1, 280, 0);
      expect_pos( 66, 1, 1, 280, 1);
      expect_pos( 90, 0, 1, 180, 0);
      expect_pos( 90, 2, 1,   0, 1);
      expect_pos( 91, 0, 1, 180, 1);
      expect_pos( 91, 2, 1,   0, 0);
      expect_pos( 92, 0, 1, 178, 1);
      expect_pos(100, 1, 0,   0, 1);
      expect_pos(101, 1, 0,   0, 0);
      expect_pos(102, 1, 0,   2, 0);
      expect_pos(170, 0, 0, 340, 0);
      expect_pos(171, 0, 0, 340, 1);
      expect_pos(172, 0, 0, 338, 1);
      expect_pos(172, 0, 1,  18, 1);
      expect_pos(172, 1, 0, 142, 0);
      expect_pos(172, 1, 1,  68, 1);
      expect_pos(172, 2, 0,  38, 1);
      expect_pos(172, 2, 1, 162, 0);

      // First tick: BUSY low in the tick cycle, high the next
      @(posedge CLK); #1 VS = 1'b0;
      @(negedge CLK);
      check("busy_in_tick_cycle", int'(BUSY), 0);
      @(negedge CLK);
      check("busy_after_tick", int'(BUSY), 1);
      repeat (5) @(posedge CLK);
      #1 VS = 1'b1;
      repeat (4) @(posedge CLK);

      for (int i = 2; i <= 172; i++) frame();
      repeat (4) @(posedge CLK);
      check("upd_cnt_run", upd_cnt, 172);
      check("pos_q_drained", pos_q.size(), 0);

      // Reset in the middle of an update (UPD1)
      pix(400, 200, 1'b0, 15, 0, 0);
      repeat (2) @(posedge CLK);
      #1 VS = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 8 && !found; i++) begin
         @(negedge CLK);
         if (dut.r_state == 2'd2) found = 1'b1;
      end
      check("reached_upd1", int'(found), 1);
      check("red_before_rst", int'(RED), 15);
      #1 RESET_N = 1'b0;
      #1;
      check("midrst_red",   int'(RED),   0);
      check("midrst_green", int'(GREEN), 0);
      check("midrst_blue",  int'(BLUE),  0);
      check("midrst_busy",  int'(BUSY),  0);
      @(posedge CLK); #1 VS = 1'b1;
      @(posedge CLK); #1 RESET_N = 1'b1;
      @(negedge CLK);
      check("midrst_state_idle", int'(dut.r_state), 0);
      check_rst_state("midrst");

      // Pause: ticks do nothing
      PAUSE = 1'b1;
      bc0 = busy_cycles;
      repeat (5) frame();
      check("paused_busy_cycles", busy_cycles - bc0, 0);
      check("paused_upd_cnt", upd_cnt, 0);
      check_rst_state("paused");

      // Single step while paused
      push_first_update();
      @(posedge CLK); #1 STEP_REQ = 1'b1;
      @(posedge CLK); #1 STEP_REQ = 1'b0;
      frame();
      check("step_upd_cnt", upd_cnt, 1);
      frame();
      check("no_extra_upd_cnt", upd_cnt, 1);
      check("no_extra_busy", busy_cycles - bc0, 3);
      check("step_hold_r0x", act_pos(0, 0), 2);
      check("step_hold_r1x", act_pos(1, 0), 198);

      repeat (3) @(posedge CLK);
      check("pos_q_empty", pos_q.size(), 0);
      check("col_q_empty", col_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
